alu_dat_mem: RTL and testbench
==============================

ALU_DAT_MEM -- requirements
Module: alu_dat_mem

Interface
REQ-001 Parameter DW, default 8: ALU operand, result and memory data width in bits.
REQ-002 Parameter AW, default 8: memory address width; depth SHALL be 2**AW words (256).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 alu_cmd  input  3  ALU operation select.
REQ-006 inA  input  DW  ALU operand A / base address.
REQ-007 inB  input  DW  ALU operand B.
REQ-008 inC  input  DW  ALU operand C / address offset.
REQ-009 rslt  output  DW  combinational ALU result; also the memory address.
REQ-010 dat_in  input  DW  memory write data.
REQ-011 wr_en  input  1  memory write enable (store).
REQ-012 dat_out  output  DW  memory read data.

Function
REQ-013 ALU SHALL be purely combinational; rslt valid in the same cycle as inputs, zero latency.
REQ-014 alu_cmd 000: rslt = inA + inB, modulo 2**DW, carry discarded.
REQ-015 alu_cmd 001: rslt = inA - inB, modulo 2**DW, borrow discarded.
REQ-016 alu_cmd 010: rslt = inA AND inB.
REQ-017 alu_cmd 011: rslt = inA OR inB.
REQ-018 alu_cmd 100: rslt = inA XOR inB.
REQ-019 alu_cmd 101: rslt = inA logically shifted left by inB[2:0], zero fill.
REQ-020 alu_cmd 110 (load address): rslt = inA + inC, modulo 2**DW.
REQ-021 alu_cmd 111 (store address): rslt = inA + inC, modulo 2**DW.
REQ-022 Memory address SHALL be rslt[AW-1:0] internally; no separate address port.
REQ-023 Write: on rising clk with wr_en=1 and reset=0, mem[rslt] <= dat_in.
REQ-024 Read: dat_out = mem[rslt] combinationally (asynchronous read), for any alu_cmd.
REQ-025 Read during write to same address: dat_out shows the old value until the edge, the new value immediately after.
REQ-026 Address wrap: rslt overflow wraps modulo 256 (e.g. 250+10 addresses word 4).
REQ-027 ALU result SHALL not depend on reset or clk.
REQ-028 wr_en=0: memory contents unchanged.

Reset
REQ-029 On a rising clk with reset=1, all 2**AW memory words SHALL be cleared to 0.
REQ-030 A write requested while reset=1 SHALL be ignored; reset wins.
REQ-031 After reset, dat_out SHALL read 0 at every address until written.
REQ-032 rslt has no reset value; it always reflects current inputs.
REQ-033 Memory contents before the first reset are undefined; verification starts with reset asserted for at least one clk edge.

Verification
REQ-034 Store: reset, then alu_cmd=111, inA=10, inC=0, dat_in=32, wr_en=1 for one edge -> rslt=10, then mem[10]=32.
REQ-035 Second store and load: alu_cmd=111, inA=4, inC=0, dat_in=46, wr_en=1, then wr_en=0, alu_cmd=110, inA=10, inC=0 -> dat_out=32 same cycle; inA=4 -> dat_out=46.
REQ-036 Arithmetic wrap: alu_cmd=000, inA=200, inB=100 -> rslt=44; alu_cmd=001, inA=5, inB=10 -> rslt=251.
REQ-037 Logic/shift: inA=0xF0, inB=0x3C -> 010: 0x30, 011: 0xFC, 100: 0xCC; alu_cmd=101, inA=0x81, inB=3 -> 0x08.
REQ-038 Reset priority: after mem[10]=32, reset=1 and wr_en=1, dat_in=99, address 10 for one edge -> mem[10]=0 and dat_out=0.
REQ-039 Address wrap: alu_cmd=111, inA=250, inC=10, dat_in=7, wr_en=1 -> rslt=4, mem[4]=7.

Source files
------------

// File: rtl/alu_dat_mem.sv
// Combinational ALU whose result also addresses a 2**AW-word data memory.
// The memory has a synchronous write and an asynchronous read, and a reset that clears every word.
module alu_dat_mem #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    alu_cmd,
   input  logic [DW-1:0] inA,
   input  logic [DW-1:0] inB,
   input  logic [DW-1:0] inC,
   output logic [DW-1:0] rslt,
   input  logic [DW-1:0] dat_in,
   input  logic          wr_en,
   output logic [DW-1:0] dat_out
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      CMD_ADD = 3'b000,
      CMD_SUB = 3'b001,
      CMD_AND = 3'b010,
      CMD_OR  = 3'b011,
      CMD_XOR = 3'b100,
      CMD_SHL = 3'b101,
      CMD_LDA = 3'b110,
      CMD_STA = 3'b111
   } alu_cmd_e;

   logic [DW-1:0] rslt_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   // ALU datapath; carries and borrows fall off the top, giving modulo 2**DW results
   always_comb begin
      rslt_s = '0;
      case (alu_cmd_e'(alu_cmd))
         CMD_ADD: rslt_s = inA + inB;
         CMD_SUB: rslt_s = inA - inB;
         CMD_AND: rslt_s = inA & inB;
         CMD_OR:  rslt_s = inA | inB;
         CMD_XOR: rslt_s = inA ^ inB;
         CMD_SHL: rslt_s = inA << inB[2:0];
         CMD_LDA: rslt_s = inA + inC;
         CMD_STA: rslt_s = inA + inC;
         default: rslt_s = '0;
      endcase
   end

   // The address is the low AW bits of the result, so address arithmetic wraps modulo DEPTH
   assign rslt   = rslt_s;
   assign addr_s = rslt_s[AW-1:0];

   // Next memory image: reset clears every word and overrides any pending write
   always_comb begin
      mem_d = mem_q;
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (wr_en) begin
         mem_d[addr_s] = dat_in;
      end else begin
         mem_d = mem_q;
      end
   end

   // Memory storage register
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Asynchronous read: shows the old word until the write edge, then the new one
   assign dat_out = mem_q[addr_s];

endmodule

// File: tb/tb_alu_dat_mem.sv
// Directed self-checking bench for alu_dat_mem with hand-computed expected values.
module tb_alu_dat_mem;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] alu_cmd;
   logic [7:0] inA, inB, inC;
   logic [7:0] rslt;
   logic [7:0] dat_in;
   logic       wr_en;
   logic [7:0] dat_out;

   int checks = 0;
   int errors = 0;

   alu_dat_mem #(.DW(8), .AW(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .alu_cmd (alu_cmd),
      .inA     (inA),
      .inB     (inB),
      .inC     (inC),
      .rslt    (rslt),
      .dat_in  (dat_in),
      .wr_en   (wr_en),
      .dat_out (dat_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] cc, input logic [7:0] d, input logic w);
      alu_cmd = c; inA = a; inB = b; inC = cc; dat_in = d; wr_en = w;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(3'b111, 8'd10, 8'd0, 8'd0, 8'd99, 1'b1);
      check("rslt_during_reset", rslt, 8'd10);
      step();
      step();
      reset = 1'b0;

      // memory reads zero everywhere after reset
      drive(3'b110, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
      check("rst_mem0", dat_out, 8'd0);
      drive(3'b110, 8'd10, 8'd0, 8'd0, 8'd0, 1'b0);
      check("rst_mem10", dat_out, 8'd0);
      drive(3'b110, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0);
      check("rst_mem255", dat_out, 8'd0);

      // store 32 at address 10: old value before edge, new value after
      drive(3'b111, 8'd10, 8'd0, 8'd0, 8'd32, 1'b1);
      check("sta_rslt", rslt, 8'd10);
      check("sta_old_before_edge", dat_out, 8'd0);
      step();
      check("sta_new_after_edge", dat_out, 8'd32);

      // store 46 at address 4, then load both
      drive(3'b111, 8'd4, 8'd0, 8'd0, 8'd46, 1'b1);
      step();
      drive(3'b110, 8'd10, 8'd0, 8'd0, 8'd255, 1'b0);
      check("lda_10", dat_out, 8'd32);
      drive(3'b110, 8'd4, 8'd0, 8'd0, 8'd255, 1'b0);
      check("lda_4", dat_out, 8'd46);
      step();
      check("wr_en0_unchanged", dat_out, 8'd46);
      drive(3'b110, 8'd2, 8'd0, 8'd2, 8'd255, 1'b0);
      check("lda_offset", dat_out, 8'd46);

      // arithmetic wrap
      drive(3'b000, 8'd200, 8'd100, 8'd0, 8'd0, 1'b0);
      check("add_wrap", rslt, 8'd44);
      drive(3'b001, 8'd5, 8'd10, 8'd0, 8'd0, 1'b0);
      check("sub_wrap", rslt, 8'd251);
      drive(3'b001, 8'd10, 8'd4, 8'd0, 8'd0, 1'b0);
      check("sub_read_addr6", rslt, 8'd6);
      drive(3'b000, 8'd3, 8'd7, 8'd0, 8'd0, 1'b0);
      check("add_read_any_cmd", dat_out, 8'd32);

      // logic and shift
      drive(3'b010, 8'hF0, 8'h3C, 8'd0, 8'd0, 1'b0);
      check("and", rslt, 8'h30);
      drive(3'b011, 8'hF0, 8'h3C, 8'd0, 8'd0, 1'b0);
      check("or", rslt, 8'hFC);
      drive(3'b100, 8'hF0, 8'h3C, 8'd0, 8'd0, 1'b0);
      check("xor", rslt, 8'hCC);
      drive(3'b101, 8'h81, 8'd3, 8'd0, 8'd0, 1'b0);
      check("shl3", rslt, 8'h08);
      drive(3'b101, 8'h81, 8'h0B, 8'd0, 8'd0, 1'b0);
      check("shl_low3_only", rslt, 8'h08);
      drive(3'b101, 8'h81, 8'd0, 8'd0, 8'd0, 1'b0);
      check("shl0", rslt, 8'h81);

      // address wrap store: 250 + 10 -> word 4
      drive(3'b111, 8'd250, 8'd0, 8'd10, 8'd7, 1'b1);
      check("wrap_rslt", rslt, 8'd4);
      step();
      check("wrap_mem4", dat_out, 8'd7);
      drive(3'b110, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
      check("wrap_lda4", dat_out, 8'd7);

      // reset wins over a simultaneous write
      reset = 1'b1;
      drive(3'b111, 8'd10, 8'd0, 8'd0, 8'd99, 1'b1);
      check("rstprio_before", dat_out, 8'd32);
      step();
      reset = 1'b0;
      drive(3'b110, 8'd10, 8'd0, 8'd0, 8'd0, 1'b0);
      check("rstprio_mem10", dat_out, 8'd0);
      drive(3'b110, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
      check("rstprio_mem4", dat_out, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
